// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] HALT_INST_EBREAK = 32'h0010_0073;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT,
        FAULT
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// PC sequencer feeding a combinational instruction memory and a
// one-entry IF/ID output stage with redirect, halt and fault handling.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     IMEM_DEPTH = 51,
    parameter logic [XLEN-1:0] HALT_INST  = HALT_INST_EBREAK
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] imem_pc_o,
    input  logic [XLEN-1:0] imem_inst_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_inst_o,
    output logic            halted_o,
    output logic            fault_o,
    output logic [XLEN-1:0] fault_pc_o,
    output logic [XLEN-1:0] inst_cnt_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_inst_q, out_inst_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [XLEN-1:0] cnt_q;

    logic acc;
    logic halt_pend;
    logic pc_legal;
    logic slot_free;

    assign acc       = valid_q & id_ready_i;
    assign halt_pend = valid_q & (out_inst_q == HALT_INST);
    assign slot_free = ~valid_q | id_ready_i;
    assign pc_legal  = (pc_q[1:0] == 2'b00) &&
                       ({2'b00, pc_q[XLEN-1:2]} < XLEN'(IMEM_DEPTH));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        fault_pc_d = fault_pc_q;
        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = RUN;
            end
            RUN: begin
                // Redirect beats everything, including an accepted EBREAK.
                if (redirect_valid_i) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_pc_i;
                end else if (slot_free && !halt_pend) begin
                    if (pc_legal) begin
                        valid_d    = 1'b1;
                        out_pc_d   = pc_q;
                        out_inst_d = imem_inst_i;
                        pc_d       = pc_q + 32'd4;
                    end else begin
                        valid_d    = 1'b0;
                        state_d    = FAULT;
                        fault_pc_d = pc_q;
                    end
                end else if (acc) begin
                    valid_d = 1'b0;
                    if (halt_pend) state_d = HALT;
                end
            end
            HALT: begin
                valid_d = 1'b0;
            end
            FAULT: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            out_pc_q   <= '0;
            out_inst_q <= '0;
            fault_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            fault_pc_q <= fault_pc_d;
            if (acc) cnt_q <= cnt_q + 32'd1;
        end
    end

    assign imem_pc_o  = pc_q;
    assign if_valid_o = valid_q;
    assign if_pc_o    = out_pc_q;
    assign if_inst_o  = out_inst_q;
    assign halted_o   = (state_q == HALT);
    assign fault_o    = (state_q == FAULT);
    assign fault_pc_o = fault_pc_q;
    assign inst_cnt_o = cnt_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a 51-word behavioural
// instruction memory.
module tb_inst_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] inst_cnt;

    logic [31:0] mem [0:50];

    int passed;
    int total;

    inst_fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .en_i             (en),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .id_ready_i       (id_ready),
        .imem_pc_o        (imem_pc),
        .imem_inst_i      (imem_inst),
        .if_valid_o       (if_valid),
        .if_pc_o          (if_pc),
        .if_inst_o        (if_inst),
        .halted_o         (halted),
        .fault_o          (fault),
        .fault_pc_o       (fault_pc),
        .inst_cnt_o       (inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_inst = 32'h0;
        if (imem_pc[31:2] < 30'd51) imem_inst = mem[imem_pc[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        passed = 0;
        total = 0;
        for (int i = 0; i < 51; i++) mem[i] = 32'h0000_0013 + (i << 20);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'h0020_81B3;
        mem[3] = 32'h0010_0073;

        // reset values
        do_reset();
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_imem_pc", imem_pc, 32'h0);
        check("rst_flags", {30'd0, halted, fault}, 32'd0);
        check("rst_cnt", inst_cnt, 32'd0);

        // 1: straight-line fetch ending in EBREAK
        en = 1'b1;
        tick();
        en = 1'b0;
        check("t1_run_valid", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_valid", {31'd0, if_valid}, 32'd1);
            check("t1_pc", if_pc, 32'(i * 4));
            check("t1_inst", if_inst, mem[i]);
        end
        tick();
        check("t1_halted", {31'd0, halted}, 32'd1);
        check("t1_valid_off", {31'd0, if_valid}, 32'd0);
        check("t1_cnt", inst_cnt, 32'd4);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        en = 1'b1;
        tick();
        redirect_valid = 1'b0;
        en = 1'b0;
        check("t1_halt_sticky", {30'd0, halted, if_valid}, 32'd2);
        check("t1_halt_pc", imem_pc, 32'h10);

        // 2: backpressure while PC 4 is presented
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        tick();
        check("t2_pc4", if_pc, 32'h4);
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_pc", if_pc, 32'h4);
            check("t2_hold_inst", if_inst, 32'h0010_0113);
            check("t2_hold_imem", imem_pc, 32'h8);
            check("t2_hold_cnt", inst_cnt, 32'd1);
        end

        // 3: redirect squashes unaccepted PC 8
        id_ready = 1'b1;
        tick();
        check("t3_pc8", if_pc, 32'h8);
        id_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        check("t3_squash", {31'd0, if_valid}, 32'd0);
        check("t3_imem", imem_pc, 32'h20);
        tick();
        check("t3_tgt_valid", {31'd0, if_valid}, 32'd1);
        check("t3_tgt_pc", if_pc, 32'h20);
        check("t3_tgt_inst", if_inst, 32'h0080_0013);
        check("t3_cnt", inst_cnt, 32'd2);

        // 4: redirect in the same cycle EBREAK is accepted
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t4_pc12", if_pc, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        check("t4_cnt", inst_cnt, 32'd4);
        check("t4_not_halted", {31'd0, halted}, 32'd0);
        check("t4_squash", {31'd0, if_valid}, 32'd0);
        tick();
        check("t4_resume_pc", if_pc, 32'h10);
        check("t4_resume_inst", if_inst, 32'h0040_0013);
        check("t4_resume_valid", {31'd0, if_valid}, 32'd1);

        // 5a: run off the end of memory
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hC4;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("t5_pc_c4", if_pc, 32'hC4);
        tick();
        check("t5_pc_c8", if_pc, 32'hC8);
        check("t5_no_fault", {31'd0, fault}, 32'd0);
        tick();
        check("t5_fault", {31'd0, fault}, 32'd1);
        check("t5_fault_pc", fault_pc, 32'hCC);
        check("t5_valid", {31'd0, if_valid}, 32'd0);
        check("t5_cnt", inst_cnt, 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check("t5_fault_sticky", {31'd0, fault}, 32'd1);
        check("t5_fault_imem", imem_pc, 32'hCC);

        // 5b: misaligned redirect target
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h06;
        tick();
        redirect_valid = 1'b0;
        check("t5b_pre", {31'd0, fault}, 32'd0);
        tick();
        check("t5b_fault", {31'd0, fault}, 32'd1);
        check("t5b_fault_pc", fault_pc, 32'h06);
        check("t5b_valid", {31'd0, if_valid}, 32'd0);

        // 6: reset while an instruction is presented
        do_reset();
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        tick();
        check("t6_pre_valid", {31'd0, if_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", {31'd0, if_valid}, 32'd0);
        check("t6_pc", if_pc, 32'h0);
        check("t6_inst", if_inst, 32'h0);
        check("t6_imem", imem_pc, 32'h0);
        check("t6_cnt", inst_cnt, 32'd0);
        check("t6_flags", {30'd0, halted, fault}, 32'd0);
        tick();
        check("t6_idle", {31'd0, if_valid}, 32'd0);
        check("t6_idle_pc", imem_pc, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
